// File: rtl/ibex_cheri_mem_exc_tracker.sv
// Queues each granted data request's CHERI fault and releases it in order with the matching rvalid.
// Optional feature: define IBEX_CHERI_EXC_ADDR_EN to also queue and report the faulting address.
module ibex_cheri_mem_exc_tracker #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CheriExcWidth  = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     data_req_i,
  input  logic                     data_gnt_i,
  input  logic                     data_rvalid_i,
  input  logic                     data_first_access_i,
  input  logic [CheriExcWidth-1:0] exc_vec_i,
  input  logic [5:0]               auth_reg_i,
`ifdef IBEX_CHERI_EXC_ADDR_EN
  input  logic [31:0]              data_addr_i,
  output logic [31:0]              exc_addr_o,
`endif
  output logic                     req_o,
  output logic                     exc_valid_o,
  output logic [4:0]               exc_cause_o,
  output logic [5:0]               exc_reg_o,
  output logic                     busy_o
);

  // Bit positions of the individual violations within exc_vec_i.
  localparam int unsigned ExcTagIdx    = 0;
  localparam int unsigned ExcSealIdx   = 1;
  localparam int unsigned ExcExecIdx   = 2;
  localparam int unsigned ExcLoadIdx   = 3;
  localparam int unsigned ExcStoreIdx  = 4;
  localparam int unsigned ExcLengthIdx = 5;

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic       fault;
    logic [4:0] cause;
    logic [5:0] cap_reg;
  } entry_t;

  function automatic entry_t encode(input logic [CheriExcWidth-1:0] vec, input logic [5:0] auth);
    entry_t e;
    e = '0;
    e.fault = 1'b1;
    if (vec[ExcTagIdx])         e.cause = 5'h02;
    else if (vec[ExcSealIdx])   e.cause = 5'h03;
    else if (vec[ExcExecIdx])   e.cause = 5'h11;
    else if (vec[ExcLoadIdx])   e.cause = 5'h12;
    else if (vec[ExcStoreIdx])  e.cause = 5'h13;
    else if (vec[ExcLengthIdx]) e.cause = 5'h01;
    else                        e.fault = 1'b0;
    e.cap_reg = e.fault ? auth : 6'h00;
    return e;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  entry_t            q_mem [MaxOutstanding];
  entry_t            sticky_q, entry_d, head;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              full, empty, push, pop;

  // Full comes straight from the count register, so a pop cannot reopen req_o in the same cycle.
  assign full    = (count_q == CntW'(MaxOutstanding));
  assign empty   = (count_q == '0);
  assign req_o   = data_req_i & ~full;
  assign push    = data_req_i & data_gnt_i & req_o;
  assign pop     = data_rvalid_i & ~empty;
  assign entry_d = data_first_access_i ? encode(exc_vec_i, auth_reg_i) : sticky_q;
  assign head    = q_mem[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        sticky_q <= entry_d;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: entries are only ever read while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) q_mem[wr_ptr_q] <= entry_d;
  end

  assign exc_valid_o = pop & head.fault;
  assign exc_cause_o = pop ? head.cause   : 5'h00;
  assign exc_reg_o   = pop ? head.cap_reg : 6'h00;
  assign busy_o      = ~empty;

`ifdef IBEX_CHERI_EXC_ADDR_EN
  logic [31:0] addr_mem [MaxOutstanding];
  logic [31:0] sticky_addr_q, addr_d;

  // Later parts of a split access report the address of the first part.
  assign addr_d = data_first_access_i ? data_addr_i : sticky_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   sticky_addr_q <= '0;
    else if (push) sticky_addr_q <= addr_d;
  end

  always_ff @(posedge clk_i) begin
    if (push) addr_mem[wr_ptr_q] <= addr_d;
  end

  assign exc_addr_o = exc_valid_o ? addr_mem[rd_ptr_q] : 32'h0;
`endif

endmodule

// File: tb/tb_ibex_cheri_mem_exc_tracker.sv
// Self-checking bench for ibex_cheri_mem_exc_tracker: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_ibex_cheri_mem_exc_tracker;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        data_req_i = 1'b0, data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_first_access_i = 1'b1;
  logic [5:0]  exc_vec_i = '0;
  logic [5:0]  auth_reg_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] exc_addr_o;
  logic        req_o, exc_valid_o, busy_o;
  logic [4:0]  exc_cause_o;
  logic [5:0]  exc_reg_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          fault;
    logic [4:0]  cause;
    logic [5:0]  creg;
    logic [31:0] addr;
  } ent_t;

  ent_t mq[$];
  ent_t sticky;

  always #5 clk = ~clk;

  ibex_cheri_mem_exc_tracker #(.MaxOutstanding(MAX), .CheriExcWidth(6)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .data_req_i          (data_req_i),
    .data_gnt_i          (data_gnt_i),
    .data_rvalid_i       (data_rvalid_i),
    .data_first_access_i (data_first_access_i),
    .exc_vec_i           (exc_vec_i),
    .auth_reg_i          (auth_reg_i),
`ifdef IBEX_CHERI_EXC_ADDR_EN
    .data_addr_i         (data_addr_i),
    .exc_addr_o          (exc_addr_o),
`endif
    .req_o               (req_o),
    .exc_valid_o         (exc_valid_o),
    .exc_cause_o         (exc_cause_o),
    .exc_reg_o           (exc_reg_o),
    .busy_o              (busy_o)
  );

`ifndef IBEX_CHERI_EXC_ADDR_EN
  assign exc_addr_o = '0;
`endif

  // Reference: vector bits listed from highest to lowest priority with their cause codes.
  function automatic ent_t model_encode(logic [5:0] vec, logic [5:0] areg, logic [31:0] addr);
    int   bit_order[6]  = '{0, 1, 2, 3, 4, 5};
    int   cause_code[6] = '{'h02, 'h03, 'h11, 'h12, 'h13, 'h01};
    ent_t e;
    e = '{fault: 1'b0, cause: 5'h00, creg: 6'h00, addr: addr};
    for (int i = 0; i < 6; i++) begin
      if (!e.fault && vec[bit_order[i]]) begin
        e.fault = 1'b1;
        e.cause = 5'(cause_code[i]);
        e.creg  = areg;
      end
    end
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string name, bit exp_req, bit has_head, ent_t h);
    check({name, ".req_o"},       32'(req_o),       32'(exp_req));
    check({name, ".busy_o"},      32'(busy_o),      32'(mq.size() > 0));
    check({name, ".exc_valid_o"}, 32'(exc_valid_o), 32'(has_head && h.fault));
    check({name, ".exc_cause_o"}, 32'(exc_cause_o), has_head ? 32'(h.cause) : 32'h0);
    check({name, ".exc_reg_o"},   32'(exc_reg_o),   has_head ? 32'(h.creg)  : 32'h0);
`ifdef IBEX_CHERI_EXC_ADDR_EN
    check({name, ".exc_addr_o"},  exc_addr_o, (has_head && h.fault) ? h.addr : 32'h0);
`endif
  endtask

  // One clock of traffic: drive after the falling edge, check mid-cycle, advance the model at the rising edge.
  task automatic step(string name, bit req, bit gnt, bit rv, bit first,
                      logic [5:0] vec, logic [5:0] areg, logic [31:0] addr);
    bit   exp_req, do_pop, do_push;
    ent_t h;
    @(negedge clk);
    data_req_i          = req;
    data_gnt_i          = gnt;
    data_rvalid_i       = rv;
    data_first_access_i = first;
    exc_vec_i           = vec;
    auth_reg_i          = areg;
    data_addr_i         = addr;
    #1;
    exp_req = req && (mq.size() < MAX);
    do_pop  = rv && (mq.size() > 0);
    do_push = exp_req && gnt;
    h = do_pop ? mq[0] : '{fault: 1'b0, cause: 5'h0, creg: 6'h0, addr: 32'h0};
    check_outputs(name, exp_req, do_pop, h);
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (first) sticky = model_encode(vec, areg, addr);
      mq.push_back(sticky);
    end
  endtask

  task automatic apply_reset(string name);
    ent_t none;
    none = '{fault: 1'b0, cause: 5'h0, creg: 6'h0, addr: 32'h0};
    @(negedge clk);
    rst_ni        = 1'b0;
    data_req_i    = 1'b1;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    mq.delete();
    sticky = none;
    #1;
    check_outputs(name, 1'b1, 1'b0, none);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    sticky = '{fault: 1'b0, cause: 5'h0, creg: 6'h0, addr: 32'h0};

    // Reset with a pending request: req_o passes through, nothing else asserted.
    apply_reset("reset");
    step("idle_after_reset", 1, 0, 0, 1, 6'h00, 6'h00, 32'h0);

    // TAG|LENGTH: TAG wins, reported on the rvalid three cycles after the grant.
    step("tag_grant", 1, 1, 0, 1, 6'b100001, 6'h05, 32'h1000);
    step("tag_wait1", 0, 0, 0, 1, 6'h00, 6'h00, 32'h0);
    step("tag_wait2", 0, 0, 0, 1, 6'h00, 6'h00, 32'h0);
    step("tag_rvalid", 0, 0, 1, 1, 6'h00, 6'h00, 32'h0);

    // Split access: second part inherits the first part's LENGTH fault and register.
    step("split_p1", 1, 1, 0, 1, 6'b100000, 6'h20, 32'h2002);
    step("split_p2", 1, 1, 0, 0, 6'h00, 6'h07, 32'h2004);
    step("split_rv1", 0, 0, 1, 1, 6'h00, 6'h00, 32'h0);
    step("split_rv2", 0, 0, 1, 1, 6'h00, 6'h00, 32'h0);

    // Full queue: simultaneous pop does not reopen req_o until the next cycle.
    step("full_g1", 1, 1, 0, 1, 6'b001000, 6'h03, 32'h3000);
    step("full_g2", 1, 1, 0, 1, 6'h00, 6'h04, 32'h3004);
    step("full_hold", 1, 1, 0, 1, 6'h00, 6'h04, 32'h3008);
    step("full_pop", 1, 1, 1, 1, 6'h00, 6'h04, 32'h3008);
    step("full_reopen", 1, 0, 1, 1, 6'h00, 6'h00, 32'h0);
    step("full_drain", 0, 0, 1, 1, 6'h00, 6'h00, 32'h0);

    // Streaming grant+rvalid every cycle with alternating STORE / clean entries.
    step("stream_prime", 1, 1, 0, 1, 6'b010000, 6'h11, 32'h4000);
    for (int i = 0; i < 10; i++)
      step($sformatf("stream_%0d", i), 1, 1, 1, 1, (i % 2 == 0) ? 6'h00 : 6'b010000,
           6'(i + 1), 32'h4000 + 32'(4 * (i + 1)));
    step("stream_drain", 0, 0, 1, 1, 6'h00, 6'h00, 32'h0);

    // Reset with two entries queued discards them; the next rvalid reports nothing.
    step("rst_q1", 1, 1, 0, 1, 6'b000001, 6'h09, 32'h5000);
    step("rst_q2", 1, 1, 0, 1, 6'b000010, 6'h0a, 32'h5004);
    apply_reset("reset_mid");
    step("rst_rvalid", 0, 0, 1, 1, 6'h00, 6'h00, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++)
      step($sformatf("rand_%0d", i), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           (mq.size() > 0) && ($urandom_range(0, 2) != 0), $urandom_range(0, 3) != 0,
           6'($urandom & $urandom), 6'($urandom), $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
